// File: rtl/spi_reg_cfg_master.sv
// SPI mode-0 master that writes or reads back one 8-bit config register of the SPI slave
// per chip-select frame: 8-bit command, optional dummy clocks (reads), then 8 data bits.
// Optional build macro SPI_CFG_READBACK_EN: every write is followed by an automatic read
// frame of the same address, and rsp_err flags a readback that differs from the write data.

module spi_reg_cfg_master #(
    parameter int unsigned CLK_DIV = 2,
    parameter logic [5:0]  WR_OP   = 6'h04,
    parameter logic [5:0]  RD_OP   = 6'h08
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [7:0] dummy_i,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       spi_sck,
    output logic       spi_csn,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StCmd,
        StDummy,
        StData,
        StHold,
        StGap
    } state_t;

    state_t     state;
    logic [7:0] div_cnt;    // counts H-1 down to 0 for each half bit
    logic       phase;      // 0: sck low half, 1: sck high half
    logic [2:0] bit_cnt;
    logic [7:0] dummy_cnt;
    logic       we_l;
    logic [7:0] wdata_l;
    logic [7:0] dummy_l;
    logic [6:0] tx_sr;      // bits still to send after the one on spi_mosi
    logic [6:0] rx_sr;
    logic       div_zero;
    logic       frame_we;   // current frame is a write frame
    logic [7:0] req_cmd;

`ifdef SPI_CFG_READBACK_EN
    logic [1:0] addr_l;
    logic       rb_active;  // current frame is the automatic readback
    assign frame_we = we_l && !rb_active;
`else
    assign frame_we = we_l;
    assign rsp_err  = 1'b0;
`endif

    assign req_ready = (state == StIdle);
    assign div_zero  = (div_cnt == 8'd0);
    assign req_cmd   = {(req_we ? WR_OP : RD_OP), req_addr};

    // Frame sequencer: all SPI pins and response outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            div_cnt   <= 8'd0;
            phase     <= 1'b0;
            bit_cnt   <= 3'd0;
            dummy_cnt <= 8'd0;
            we_l      <= 1'b0;
            wdata_l   <= 8'd0;
            dummy_l   <= 8'd0;
            tx_sr     <= 7'd0;
            rx_sr     <= 7'd0;
            spi_sck   <= 1'b0;
            spi_csn   <= 1'b1;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
`ifdef SPI_CFG_READBACK_EN
            addr_l    <= 2'd0;
            rb_active <= 1'b0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        we_l     <= req_we;
                        wdata_l  <= req_wdata;
                        dummy_l  <= dummy_i;
`ifdef SPI_CFG_READBACK_EN
                        addr_l    <= req_addr;
                        rb_active <= 1'b0;
`endif
                        spi_csn  <= 1'b0;
                        spi_mosi <= req_cmd[7];
                        tx_sr    <= req_cmd[6:0];
                        div_cnt  <= DIV_LAST;
                        state    <= StSetup;
                    end
                end
                StSetup: begin
                    if (div_zero) begin
                        state   <= StCmd;
                        div_cnt <= DIV_LAST;
                        phase   <= 1'b0;
                        bit_cnt <= 3'd7;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                StCmd, StDummy, StData: begin
                    if (!div_zero) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (!phase) begin
                        // Rising sck: sample miso
                        div_cnt <= DIV_LAST;
                        phase   <= 1'b1;
                        spi_sck <= 1'b1;
                        rx_sr   <= {rx_sr[5:0], spi_miso};
                        if (state == StData && bit_cnt == 3'd0 && !frame_we) begin
                            rsp_rdata <= {rx_sr, spi_miso};
`ifdef SPI_CFG_READBACK_EN
                            rsp_err   <= rb_active && ({rx_sr, spi_miso} != wdata_l);
`endif
                        end
                    end else begin
                        // Falling sck: advance to the next bit
                        div_cnt <= DIV_LAST;
                        phase   <= 1'b0;
                        spi_sck <= 1'b0;
                        if (state == StDummy) begin
                            if (dummy_cnt == 8'd1) begin
                                state <= StData;
                            end
                            dummy_cnt <= dummy_cnt - 8'd1;
                        end else if (bit_cnt != 3'd0) begin
                            bit_cnt  <= bit_cnt - 3'd1;
                            spi_mosi <= tx_sr[6];
                            tx_sr    <= {tx_sr[5:0], 1'b0};
                        end else if (state == StCmd) begin
                            bit_cnt <= 3'd7;
                            if (!frame_we && dummy_l != 8'd0) begin
                                state     <= StDummy;
                                dummy_cnt <= dummy_l;
                                spi_mosi  <= 1'b0;
                                tx_sr     <= 7'd0;
                            end else if (frame_we) begin
                                state    <= StData;
                                spi_mosi <= wdata_l[7];
                                tx_sr    <= wdata_l[6:0];
                            end else begin
                                state    <= StData;
                                spi_mosi <= 1'b0;
                                tx_sr    <= 7'd0;
                            end
                        end else begin
                            state    <= StHold;
                            spi_mosi <= 1'b0;
                        end
                    end
                end
                StHold: begin
                    if (div_zero) begin
                        spi_csn <= 1'b1;
                        state   <= StGap;
                        div_cnt <= DIV_LAST;
                        phase   <= 1'b0;
`ifdef SPI_CFG_READBACK_EN
                        // A write frame is only half of the transaction here
                        rsp_valid <= !(we_l && !rb_active);
`else
                        rsp_valid <= 1'b1;
`endif
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                StGap: begin
                    if (!div_zero) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (!phase) begin
                        phase   <= 1'b1;
                        div_cnt <= DIV_LAST;
                    end else begin
                        phase <= 1'b0;
`ifdef SPI_CFG_READBACK_EN
                        if (we_l && !rb_active) begin
                            rb_active <= 1'b1;
                            spi_csn   <= 1'b0;
                            spi_mosi  <= RD_OP[5];
                            tx_sr     <= {RD_OP[4:0], addr_l};
                            div_cnt   <= DIV_LAST;
                            state     <= StSetup;
                        end else begin
                            rb_active <= 1'b0;
                            state     <= StIdle;
                        end
`else
                        state <= StIdle;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
